// File: rtl/fft_frame_sequencer.sv
// Burst sequencer for the R2^2 SDF FFT pipeline: gates the AXI-Stream input, drives the
// datapath advance enable and stage counter, and tracks pipeline fill/flush for output valid/last.
module fft_frame_sequencer #(
  parameter int CNT_W   = 10,
  parameter int BURST_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [10:0]        i_point,
  input  logic [BURST_W-1:0] i_burst,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  input  logic               m_axis_tready,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  output logic               o_en,
  output logic [CNT_W-1:0]   o_stage_cnt,
  output logic [10:0]        o_point,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t             state, state_nxt;
  logic               start_d, filled, err_q, rdy;
  logic [10:0]        point_q;
  logic [BURST_W-1:0] burst_q, in_frames, out_frames;
  logic [CNT_W-1:0]   mask_q, adv_cnt, out_cnt;
  logic               start_pulse, cfg_ok, accept, in_last, last_frame_in, last_frame_out;

  assign start_pulse    = i_start & ~start_d;
  assign cfg_ok         = (i_point inside {11'd16, 11'd32, 11'd64, 11'd128, 11'd256, 11'd512, 11'd1024})
                          && (i_burst != '0);
  assign accept         = s_axis_tvalid & s_axis_tready;
  assign in_last        = accept & (adv_cnt == mask_q);
  assign last_frame_in  = (in_frames == burst_q - 1'b1);
  assign last_frame_out = (out_frames == burst_q - 1'b1);

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_pulse && cfg_ok) state_nxt = RUN;
      RUN:     if (in_last && last_frame_in) state_nxt = FLUSH;
      FLUSH:   if (m_axis_tlast && last_frame_out) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy    = 1'b0;
    o_en   = 1'b0;
    o_busy = 1'b0;
    o_done = 1'b0;
    unique case (state)
      RUN: begin
        // Before the pipe is full nothing leaves, so downstream backpressure is irrelevant
        rdy    = ~filled | m_axis_tready;
        o_en   = s_axis_tvalid & rdy;
        o_busy = 1'b1;
      end
      FLUSH: begin
        o_en   = m_axis_tready;
        o_busy = 1'b1;
      end
      DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign s_axis_tready = rdy;
  assign m_axis_tvalid = o_en & filled;
  assign m_axis_tlast  = m_axis_tvalid & (out_cnt == mask_q);
  assign o_stage_cnt   = adv_cnt;
  assign o_point       = point_q;
  assign o_err         = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_d    <= 1'b0;
      err_q      <= 1'b0;
      filled     <= 1'b0;
      point_q    <= '0;
      burst_q    <= '0;
      mask_q     <= '0;
      adv_cnt    <= '0;
      out_cnt    <= '0;
      in_frames  <= '0;
      out_frames <= '0;
    end else begin
      start_d <= i_start;
      // Registered error pulse: illegal config at an idle start, or input tlast out of step with the counter
      err_q   <= (state == IDLE && start_pulse && !cfg_ok) ||
                 (accept && (s_axis_tlast != (adv_cnt == mask_q)));
      if (state == DONE) begin
        filled     <= 1'b0;
        point_q    <= '0;
        burst_q    <= '0;
        mask_q     <= '0;
        adv_cnt    <= '0;
        out_cnt    <= '0;
        in_frames  <= '0;
        out_frames <= '0;
      end else if (state == IDLE) begin
        if (start_pulse && cfg_ok) begin
          point_q    <= i_point;
          burst_q    <= i_burst;
          mask_q     <= i_point[CNT_W-1:0] - 1'b1;
          filled     <= 1'b0;
          adv_cnt    <= '0;
          out_cnt    <= '0;
          in_frames  <= '0;
          out_frames <= '0;
        end
      end else begin
        if (o_en) adv_cnt <= (adv_cnt + 1'b1) & mask_q;
        // N-1 advances done once the counter leaves M-1 for the first time
        if (o_en && adv_cnt == mask_q - 1'b1) filled <= 1'b1;
        if (m_axis_tvalid) out_cnt <= (out_cnt + 1'b1) & mask_q;
        if (m_axis_tlast) out_frames <= out_frames + 1'b1;
        if (in_last) in_frames <= in_frames + 1'b1;
      end
    end
  end

endmodule
